// File: rtl/adder_sequencer.sv
// adder_sequencer: performs one 16-bit addition as four nibble steps through
// an external 4-bit adder. Nibble 0 is issued first, and the carry is chained
// from one nibble to the next. Result, carry-out and signed overflow are
// registered, and done pulses for one cycle when they become valid.
// Optional feature: define ADDER_SEQUENCER_SUB_EN to add a 'sub' input that
// turns the operation into op_a - op_b.
module adder_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
`ifdef ADDER_SEQUENCER_SUB_EN
    input  logic        sub,
`endif
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    input  logic        cin_in,
    output logic [3:0]  add_a,
    output logic [3:0]  add_b,
    output logic        add_cin,
    input  logic [3:0]  add_s,
    input  logic        add_cout,
    input  logic        add_ovf,
    output logic [15:0] sum,
    output logic        cout,
    output logic        ovf,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_idx;
    logic        r_carry;
    logic [15:0] r_op_a;
    logic [15:0] r_op_b;
    logic [15:0] r_sum;
    logic        r_cout;
    logic        r_ovf;
    logic        r_busy;
    logic        r_done;

    logic [15:0] w_op_b;
    logic        w_cin;
    logic [3:0]  w_lsb;

    // Select the operand B and initial carry to capture: subtraction stores ~op_b with carry 1.
    always_comb begin
`ifdef ADDER_SEQUENCER_SUB_EN
        w_op_b = sub ? ~op_b : op_b;
        w_cin  = sub ? 1'b1  : cin_in;
`else
        w_op_b = op_b;
        w_cin  = cin_in;
`endif
    end

    // Bit offset of the current nibble.
    assign w_lsb = {r_idx, 2'b00};

    // Drive the external adder with the current nibble during RUN, and drive zeros otherwise.
    always_comb begin
        // NOTE: each output gets a default before the conditional, so no path
        // leaves it unassigned and no latch is inferred.
        add_a   = 4'd0;
        add_b   = 4'd0;
        add_cin = 1'b0;
        if (r_state == ST_RUN) begin
            add_a   = r_op_a[w_lsb +: 4];
            add_b   = r_op_b[w_lsb +: 4];
            add_cin = r_carry;
        end
    end

    // Sequencer FSM with all outputs registered; reset aborts any operation without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= 2'd0;
            r_carry <= 1'b0;
            r_op_a  <= 16'd0;
            r_op_b  <= 16'd0;
            r_sum   <= 16'd0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here mean every right-hand side
            // reads the pre-edge value. For example, the sum slice is
            // selected by the old r_idx even though r_idx is incremented in
            // the same branch.
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op_a  <= op_a;
                        r_op_b  <= w_op_b;
                        r_carry <= w_cin;
                        r_idx   <= 2'd0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sum[w_lsb +: 4] <= add_s;
                    r_carry           <= add_cout;
                    r_idx             <= r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        r_cout  <= add_cout;
                        r_ovf   <= add_ovf;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_adder_sequencer.sv
// Testbench for adder_sequencer. A behavioural 4-bit adder is attached to
// the DUT. Expected 16-bit results are queued when an operation is driven and
// are compared whenever done pulses. Define ADDER_SEQUENCER_SUB_EN to also
// exercise subtraction.
module tb_adder_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        cin_in;
    logic        sub_sel;
`ifdef ADDER_SEQUENCER_SUB_EN
    logic        sub;
    assign sub = sub_sel;
`endif
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_cin;
    logic [3:0]  add_s;
    logic        add_cout;
    logic        add_ovf;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;
    logic        done;

    adder_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
`ifdef ADDER_SEQUENCER_SUB_EN
        .sub      (sub),
`endif
        .op_a     (op_a),
        .op_b     (op_b),
        .cin_in   (cin_in),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout),
        .add_ovf  (add_ovf),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf),
        .busy     (busy),
        .done     (done)
    );

    // External 4-bit adder: sum, carry-out, and two's-complement overflow.
    logic [4:0] w_nib;
    assign w_nib    = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
    assign add_s    = w_nib[3:0];
    assign add_cout = w_nib[4];
    assign add_ovf  = (add_a[3] == add_b[3]) && (w_nib[3] != add_a[3]);

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    res_t sb[$];
    res_t mon_exp;
    res_t last_res;
    int   n_cmp    = 0;
    int   n_err    = 0;
    int   n_done   = 0;
    int   n_expect = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference result of the whole 16-bit operation.
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic s);
        res_t        r;
        logic [15:0] bb;
        logic        c;
        logic [16:0] t;
        bb     = s ? ~b : b;
        c      = s ? 1'b1 : cin;
        t      = {1'b0, a} + {1'b0, bb} + {16'd0, c};
        r.sum  = t[15:0];
        r.cout = t[16];
        r.ovf  = (a[15] == bb[15]) && (t[15] != a[15]);
        return r;
    endfunction

    // Scoreboard: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_exp = sb.pop_front();
                check("sum",  {16'd0, sum},  {16'd0, mon_exp.sum});
                check("cout", {31'd0, cout}, {31'd0, mon_exp.cout});
                check("ovf",  {31'd0, ovf},  {31'd0, mon_exp.ovf});
                last_res = mon_exp;
            end
        end
    end

    // Watchdog for any unbounded stall.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Runs one operation. Called at a negedge; returns at a negedge.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic s);
        int k;
        k = 0;
        while (busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
        start   = 1'b1;
        op_a    = a;
        op_b    = b;
        cin_in  = cin;
        sub_sel = s;
        sb.push_back(model(a, b, cin, s));
        n_expect++;
        @(posedge clk);
        #1;
        // Scramble the inputs so that the result must come from the latched copies.
        start  = 1'b0;
        op_a   = 16'($urandom);
        op_b   = 16'($urandom);
        cin_in = 1'($urandom);
        k = 0;
        while (k < 10) begin
            @(negedge clk);
            k++;
            if (k == 1) check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            if (done) break;
        end
        check({tag, "_latency"}, k, 32'd5);
        @(negedge clk);
        check({tag, "_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_hold"}, {16'd0, sum}, {16'd0, last_res.sum});
    endtask

    initial begin
        int k;
        int first;
        int second;
        int snap;
        rst     = 1'b1;
        start   = 1'b0;
        op_a    = 16'hABCD;
        op_b    = 16'h1234;
        cin_in  = 1'b1;
        sub_sel = 1'b0;
        last_res = '0;
        #1;
        check("rst_busy",  {31'd0, busy},   32'd0);
        check("rst_done",  {31'd0, done},   32'd0);
        check("rst_sum",   {16'd0, sum},    32'd0);
        check("rst_flags", {30'd0, cout, ovf}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("idle_add_a",   {28'd0, add_a},   32'd0);
        check("idle_add_b",   {28'd0, add_b},   32'd0);
        check("idle_add_cin", {31'd0, add_cin}, 32'd0);

        // Start on the first edge after reset release.
        run_op("carry_chain", 16'h00FF, 16'h0001, 1'b0, 1'b0);
        run_op("wrap",        16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op("pos_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0);
        run_op("cin_only",    16'h0000, 16'h0000, 1'b1, 1'b0);
        run_op("all_ones",    16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        run_op("neg_ovf",     16'h8000, 16'h8000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            run_op("random", 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);

        // Hold start high across a whole operation while changing the operands during RUN.
        start  = 1'b1;
        op_a   = 16'h1111;
        op_b   = 16'h2222;
        cin_in = 1'b0;
        sb.push_back(model(16'h1111, 16'h2222, 1'b0, 1'b0));
        n_expect++;
        @(posedge clk);
        #1;
        op_a   = 16'h0F0F;
        op_b   = 16'h0101;
        cin_in = 1'b1;
        sb.push_back(model(16'h0F0F, 16'h0101, 1'b1, 1'b0));
        n_expect++;
        k = 0; first = 0; second = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (done) begin
                if (first == 0) first = k;
                else begin
                    second = k;
                    break;
                end
            end
            if (k == 6) check("held_idle_gap", {31'd0, busy}, 32'd0);
            if (k == 7) begin
                check("held_second_accept", {31'd0, busy}, 32'd1);
                start = 1'b0;
            end
        end
        check("held_first_done",  first,  32'd5);
        check("held_second_done", second, 32'd11);
        @(negedge clk);

        // Assert reset while idx = 2.
        start  = 1'b1;
        op_a   = 16'hAAAA;
        op_b   = 16'h5555;
        cin_in = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        snap = n_done;
        #1;
        check("midrst_busy",  {31'd0, busy},  32'd0);
        check("midrst_sum",   {16'd0, sum},   32'd0);
        check("midrst_done",  {31'd0, done},  32'd0);
        check("midrst_add_a", {28'd0, add_a}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("midrst_no_done", n_done - snap, 32'd0);
        run_op("after_rst", 16'h1234, 16'h1111, 1'b0, 1'b0);
        check("after_rst_value", {16'd0, sum}, 32'h2345);

`ifdef ADDER_SEQUENCER_SUB_EN
        run_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1);
        run_op("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1);
        run_op("sub_cin_ign", 16'h0009, 16'h0003, 1'b1, 1'b1);
`endif

        repeat (3) @(negedge clk);
        check("done_count", n_done, n_expect);
        check("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adder_sequencer.md
ADDER_SEQUENCER -- requirements
Module: adder_sequencer

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 The module SHALL have port start, input, 1 bit: request for one 16-bit addition, sampled only in IDLE.
REQ-004 The module SHALL have ports op_a and op_b, input, 16 bits each: operands, captured on an accepted start.
REQ-005 The module SHALL have port cin_in, input, 1 bit: carry-in of the 16-bit operation, captured with the operands.
REQ-006 The module SHALL have ports add_a and add_b, output, 4 bits each, and add_cin, output, 1 bit: operands driven to the external 4-bit adder.
REQ-007 The module SHALL have ports add_s, input, 4 bits, and add_cout and add_ovf, input, 1 bit each: results returned by the 4-bit adder in the same cycle.
REQ-008 The module SHALL have port sum, output, 16 bits: registered result.
REQ-009 The module SHALL have ports cout and ovf, output, 1 bit each: registered carry-out and signed-overflow flags of the 16-bit result.
REQ-010 The module SHALL have port busy, output, 1 bit: high while in RUN or DONE.
REQ-011 The module SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.

Function
REQ-012 The FSM SHALL have three states, IDLE, RUN and DONE, plus a 2-bit nibble index idx and a 1-bit carry register.
REQ-013 In IDLE with start=1, the next edge SHALL latch op_a, op_b and cin_in, set idx=0, set carry=cin_in, and enter RUN.
REQ-014 In RUN, add_a, add_b and add_cin SHALL be driven combinationally: add_a=op_a[4*idx+3:4*idx], add_b=op_b[4*idx+3:4*idx] (latched copies), add_cin=carry.
REQ-015 On each RUN edge, sum[4*idx+3:4*idx] SHALL take add_s, carry SHALL take add_cout, and idx SHALL increment.
REQ-016 On the RUN edge with idx=3, cout SHALL take add_cout, ovf SHALL take add_ovf, and the FSM SHALL enter DONE.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-018 Latency SHALL be fixed: with start accepted at edge N, done=1 SHALL hold in the cycle after edge N+4, and sum, cout and ovf SHALL be valid from that cycle.
REQ-019 sum, cout and ovf SHALL hold their values until the next accepted start; sum nibbles SHALL update progressively during RUN.
REQ-020 start SHALL be ignored in RUN and DONE; back-to-back operations SHALL need start high in IDLE, giving a minimum spacing of 6 cycles.
REQ-021 Outside RUN, add_a, add_b and add_cin SHALL be driven to 0.

Reset
REQ-022 Asserting rst SHALL force IDLE and clear idx, carry, the latched operands, sum, cout, ovf, busy and done immediately, including mid-RUN, with no done pulse.
REQ-023 After rst deasserts, the first rising edge with start=1 SHALL be accepted.

Configuration
REQ-024 With macro ADDER_SEQUENCER_SUB_EN defined, the module SHALL have an extra 1-bit input sub, captured with the operands.
REQ-025 With ADDER_SEQUENCER_SUB_EN defined and sub=1, the module SHALL latch ~op_b, force the initial carry to 1 and ignore cin_in, giving sum=op_a-op_b with cout=1 meaning no borrow.
REQ-026 With ADDER_SEQUENCER_SUB_EN undefined, the sub port and its logic SHALL be absent, and the block SHALL only add.

Verification
REQ-027 With the real adder attached: op_a=0x00FF, op_b=0x0001, cin_in=0 -> sum=0x0100, cout=0, ovf=0, and done exactly 5 cycles after the start edge.
REQ-028 op_a=0xFFFF, op_b=0x0001, cin_in=0 -> sum=0x0000, cout=1, ovf=0; op_a=0x7FFF, op_b=0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-029 op_a=0x0000, op_b=0x0000, cin_in=1 -> sum=0x0001; op_a=0xFFFF, op_b=0xFFFF, cin_in=1 -> sum=0xFFFF, cout=1, ovf=0.
REQ-030 start held high through a whole operation with new operands applied during RUN -> exactly one done pulse, result from the first operands, and the second operation accepted only once back in IDLE.
REQ-031 rst pulsed while idx=2 -> busy=0, sum=0, and no done pulse; a following start with op_a=0x1234, op_b=0x1111 -> sum=0x2345.
REQ-032 With ADDER_SEQUENCER_SUB_EN defined: sub=1, op_a=0x0005, op_b=0x0007 -> sum=0xFFFE, cout=0; sub=1, op_a=0x8000, op_b=0x0001 -> sum=0x7FFF, ovf=1.
